regfile_dump: RTL

Sequential reader for the 32x32 register file: on command it walks a contiguous (wrap-around) range of register addresses through one combinational read port and streams each word out over a valid/ready interface. It sits beside the register file on a spare read port (the T port in debug mode) and feeds the debug/trace path. It lets software and testbenches snapshot architectural state, including R[0]=0 and the R[29] reset value 0x3FC, without stalling the pipeline's write port.

---
 rtl/regfile_dump_if.sv | 38 +++
 rtl/regfile_dump.sv | 119 +++++++++++
 2 files changed

// File: rtl/regfile_dump_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_dump_if
// Description : Command, register-file read port and output stream bundle
//               for the sequential register-file dumper.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_dump_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          start;
    logic          abort;
    logic [AW-1:0] first_addr;
    logic [AW-1:0] last_addr;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_last;
    logic          busy;
    logic          done;

    // Dumper side: takes commands and read data, produces the stream.
    modport slave (
        input  start, abort, first_addr, last_addr, rd_data, out_ready,
        output rd_addr, out_valid, out_data, out_addr, out_last, busy, done
    );

    // Controller / consumer / register-file side.
    modport master (
        output start, abort, first_addr, last_addr, rd_data, out_ready,
        input  rd_addr, out_valid, out_data, out_addr, out_last, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/regfile_dump.sv
`default_nettype none
// ============================================================================
// Module      : regfile_dump
// Description : Walks a wrap-around range of register addresses through one
//               combinational read port and streams each word out over a
//               valid/ready interface. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_dump #(
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  wire logic      clk,
    input  wire logic      rst,     // asynchronous, active low
    regfile_dump_if.slave  bus
);
    localparam logic [AW-1:0] C_TOP_REG = AW'(NREGS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_cur;
    logic [AW-1:0] r_last;
    logic [AW-1:0] r_rd_addr;
    logic          r_out_valid;
    logic [DW-1:0] r_out_data;
    logic [AW-1:0] r_out_addr;
    logic          r_out_last;
    logic          r_busy;
    logic          r_done;
    logic          w_handshake;
    logic [AW-1:0] w_cur_inc;

    assign w_handshake = r_out_valid && bus.out_ready;
    // Explicit wrap keeps the walk modulo NREGS.
    assign w_cur_inc   = (r_cur == C_TOP_REG) ? '0 : r_cur + 1'b1;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Next-state logic; abort outranks everything once a dump is running.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.start && !bus.abort) w_next = S_FETCH;
            S_FETCH: w_next = bus.abort ? S_IDLE : S_HOLD;
            S_HOLD: begin
                if (bus.abort)       w_next = S_IDLE;
                else if (w_handshake) w_next = r_out_last ? S_DONE : S_FETCH;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath and registered status outputs, all derived from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cur       <= '0;
            r_last      <= '0;
            r_rd_addr   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_addr  <= '0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_busy      <= (w_next != S_IDLE);
            r_done      <= (w_next == S_DONE);
            r_out_valid <= (w_next == S_HOLD);
            unique case (r_state)
                S_IDLE: begin
                    if (w_next == S_FETCH) begin
                        r_last    <= bus.last_addr;
                        r_cur     <= bus.first_addr;
                        r_rd_addr <= bus.first_addr;
                    end
                end
                S_FETCH: begin
                    // Read data sampled at the end of the fetch cycle, so a
                    // negedge write inside this cycle is included.
                    if (w_next == S_HOLD) begin
                        r_out_data <= bus.rd_data;
                        r_out_addr <= r_cur;
                        r_out_last <= (r_cur == r_last);
                    end
                end
                S_HOLD: begin
                    if (w_next == S_FETCH) begin
                        r_cur     <= w_cur_inc;
                        r_rd_addr <= w_cur_inc;
                    end
                end
                default: ;
            endcase
            if (bus.abort && (r_state != S_IDLE)) r_out_last <= 1'b0;
        end
    end

    assign bus.rd_addr   = r_rd_addr;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_addr  = r_out_addr;
    assign bus.out_last  = r_out_last;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
endmodule
`default_nettype wire
